// File: rtl/vdp_pkg.sv
// vdp_pkg -- shared definitions for the VDP CPU interface: I/O port numbers,
// bus-arbiter FSM states and the CPU write-buffer entry layout.
package vdp_pkg;

  // I/O port numbers decoded by the CPU interface
  localparam logic [7:0] PORT_RD_BANK = 8'hF1;
  localparam logic [7:0] PORT_WR_MASK = 8'hF2;
  localparam logic [7:0] PORT_P1      = 8'hF5;
  localparam logic [7:0] PORT_P2      = 8'hF6;
  localparam logic [7:0] PORT_P3      = 8'hF7;
  localparam logic [7:0] PORT_P4      = 8'hF8;
  localparam logic [7:0] PORT_P5      = 8'hF9;
  localparam logic [7:0] PORT_P6      = 8'hFA;
  localparam logic [7:0] PORT_CMASK   = 8'hFB;
  localparam logic [7:0] PORT_BGC     = 8'hFC;
  localparam logic [7:0] PORT_MASK    = 8'hFE;

  // Address width carried in a buffered write (covers the full CPU window)
  localparam int ENTRY_AW = 13;
  localparam int NPLANES  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ADDR,
    ST_RD_DATA
  } vdp_state_e;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [7:0]          data;
    logic [NPLANES-1:0]  mask;
  } wr_entry_t;

  // Plane numbers 1..6 exist; 0 and 7 read back as open bus
  function automatic logic bank_valid(input logic [2:0] bank);
    return (bank != 3'd0) && (bank != 3'd7);
  endfunction

endpackage

// File: rtl/vdp_wfifo.sv
// vdp_wfifo -- CPU write buffer. Holds {addr, data, mask} entries until the
// arbiter finds a CPU-owned VRAM slot. A push is accepted while full only if
// a pop happens in the same cycle, so occupancy stays unchanged.
module vdp_wfifo
  import vdp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wr_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Entry storage
  // NOTE: storage is not reset -- entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy
  // NOTE: non-blocking assignments keep every flop reading pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vdp_cpuif.sv
// vdp_cpuif -- Z80 side of the VDP: I/O register file, buffered VRAM writes,
// stalled VRAM reads, all arbitrated against the video fetch slot (vclk).
// vclk is sampled on clk: a VRAM operation is only launched from an edge that
// sees vclk low. Optional build macro VDP_READBACK_EN enables register readback
// on io_dout; without it io_dout reads 8'hFF.
module vdp_cpuif
  import vdp_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int VRAM_AW    = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vclk,
  input  logic               io_wr,
  input  logic               io_rd,
  input  logic [7:0]         io_addr,
  input  logic [7:0]         io_din,
  output logic [7:0]         io_dout,
  input  logic               mem_cs,
  input  logic               mem_wr,
  input  logic               mem_rd,
  input  logic [VRAM_AW-1:0] mem_addr,
  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic               cpu_wait,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [5:0]         vram_we,
  output logic [7:0]         vram_wdata,
  output logic [2:0]         vram_rsel,
  input  logic [7:0]         vram_rdata,
  output logic [7:0]         p1,
  output logic [7:0]         p2,
  output logic [7:0]         p3,
  output logic [7:0]         p4,
  output logic [7:0]         p5,
  output logic [7:0]         p6,
  output logic [7:0]         cmask,
  output logic [7:0]         bgc,
  output logic [7:0]         mask
);

  // Register file
  logic [2:0]       rd_bank;
  logic [5:0]       wr_mask;
  logic [7:0]       pal [6];

  // Write path
  wr_entry_t        new_entry;
  wr_entry_t        hold_entry;
  logic             hold_valid;
  logic             hold_take;
  wr_entry_t        fifo_din;
  wr_entry_t        fifo_dout;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  // Read path / arbiter
  vdp_state_e       state;
  logic             rd_pending;
  logic [VRAM_AW-1:0] rd_addr;
  logic             mem_wr_req;
  logic             mem_rd_req;

  assign mem_wr_req = mem_cs & mem_wr;
  assign mem_rd_req = mem_cs & mem_rd;

  assign p1 = pal[0];
  assign p2 = pal[1];
  assign p3 = pal[2];
  assign p4 = pal[3];
  assign p5 = pal[4];
  assign p6 = pal[5];

  // I/O register writes land on the edge that samples io_wr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_bank <= '0;
      wr_mask <= '0;
      for (int i = 0; i < 6; i++) pal[i] <= '0;
      cmask   <= '0;
      bgc     <= '0;
      mask    <= '0;
    end else if (io_wr) begin
      case (io_addr)
        PORT_RD_BANK: rd_bank <= io_din[2:0];
        PORT_WR_MASK: wr_mask <= io_din[5:0];
        PORT_P1:      pal[0]  <= io_din;
        PORT_P2:      pal[1]  <= io_din;
        PORT_P3:      pal[2]  <= io_din;
        PORT_P4:      pal[3]  <= io_din;
        PORT_P5:      pal[4]  <= io_din;
        PORT_P6:      pal[5]  <= io_din;
        PORT_CMASK:   cmask   <= io_din;
        PORT_BGC:     bgc     <= io_din;
        PORT_MASK:    mask    <= io_din;
        default:      ;
      endcase
    end
  end

`ifdef VDP_READBACK_EN
  logic [7:0] io_dout_q;

  // Register readback, presented the cycle after io_rd
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_dout_q <= 8'hFF;
    end else if (io_rd) begin
      case (io_addr)
        PORT_RD_BANK: io_dout_q <= {5'b0, rd_bank};
        PORT_WR_MASK: io_dout_q <= {2'b0, wr_mask};
        PORT_P1:      io_dout_q <= pal[0];
        PORT_P2:      io_dout_q <= pal[1];
        PORT_P3:      io_dout_q <= pal[2];
        PORT_P4:      io_dout_q <= pal[3];
        PORT_P5:      io_dout_q <= pal[4];
        PORT_P6:      io_dout_q <= pal[5];
        PORT_CMASK:   io_dout_q <= cmask;
        PORT_BGC:     io_dout_q <= bgc;
        PORT_MASK:    io_dout_q <= mask;
        default:      io_dout_q <= 8'hFF;
      endcase
    end
  end

  assign io_dout = io_dout_q;
`else
  assign io_dout = 8'hFF;
`endif

  // The write mask is captured with the data, so later wr_mask changes never
  // retarget a buffered write.
  always_comb begin
    new_entry.addr = ENTRY_AW'(mem_addr);
    new_entry.data = mem_din;
    new_entry.mask = wr_mask;
  end

  // Select FIFO input: a held (stalled) write has priority over a fresh one
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    fifo_din  = new_entry;
    fifo_push = 1'b0;
    hold_take = 1'b0;
    if (hold_valid) begin
      fifo_din  = hold_entry;
      fifo_push = !fifo_full || fifo_pop;
    end else if (mem_wr_req) begin
      if (fifo_full) hold_take = 1'b1;
      else           fifo_push = 1'b1;
    end
  end

  // Stall register for a write that arrived with the FIFO full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_entry <= '0;
    end else if (hold_take) begin
      hold_valid <= 1'b1;
      hold_entry <= new_entry;
    end else if (hold_valid && fifo_push) begin
      hold_valid <= 1'b0;
    end
  end

  vdp_wfifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head entry is consumed on the edge that launches WRITE
  assign fifo_pop = (state == ST_IDLE) && !vclk && !fifo_empty;

  // Stall the CPU for any outstanding read, or a write that cannot be buffered
  assign cpu_wait = rd_pending | hold_valid | mem_rd_req |
                    (mem_wr_req & fifo_full);

  // VRAM arbiter: writes drain before any read, only in CPU-owned slots
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rd_pending <= 1'b0;
      rd_addr    <= '0;
      mem_dout   <= '0;
      vram_addr  <= '0;
      vram_we    <= '0;
      vram_wdata <= '0;
      vram_rsel  <= '0;
    end else begin
      vram_we <= '0;

      if (mem_rd_req) begin
        if (bank_valid(rd_bank)) begin
          rd_pending <= 1'b1;
          rd_addr    <= mem_addr;
        end else begin
          mem_dout   <= 8'hFF;
        end
      end

      case (state)
        ST_IDLE: begin
          if (!vclk) begin
            if (!fifo_empty) begin
              state      <= ST_WRITE;
              vram_addr  <= VRAM_AW'(fifo_dout.addr);
              vram_wdata <= fifo_dout.data;
              vram_we    <= fifo_dout.mask;
            end else if (rd_pending && !hold_valid) begin
              state      <= ST_RD_ADDR;
              vram_addr  <= rd_addr;
              vram_rsel  <= rd_bank;
            end
          end
        end
        ST_WRITE:   state <= ST_IDLE;
        ST_RD_ADDR: state <= ST_RD_DATA;
        ST_RD_DATA: begin
          mem_dout   <= vram_rdata;
          rd_pending <= 1'b0;
          state      <= ST_IDLE;
        end
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_cpuif.sv
// tb_vdp_cpuif -- scoreboard bench for vdp_cpuif. Stimulus pushes expected
// VRAM writes and CPU read data into queues; a monitor pops and compares
// whenever the DUT pulses vram_we or releases cpu_wait.
module tb_vdp_cpuif;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    logic [5:0]  we;
  } exp_wr_t;

  logic        clk, reset, vclk;
  logic        io_wr, io_rd;
  logic [7:0]  io_addr, io_din, io_dout;
  logic        mem_cs, mem_wr, mem_rd;
  logic [12:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        cpu_wait;
  logic [12:0] vram_addr;
  logic [5:0]  vram_we;
  logic [7:0]  vram_wdata;
  logic [2:0]  vram_rsel;
  logic [7:0]  vram_rdata;
  logic [7:0]  p1, p2, p3, p4, p5, p6, cmask, bgc, mask;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_wr_t     exp_wr_q[$];
  logic [7:0]  rd_q[$];
  logic        vclk_at_edge;
  logic        wait_prev;
  logic [7:0]  plane [1:6][0:8191];

  vdp_cpuif #(.FIFO_DEPTH(2), .VRAM_AW(13)) dut (
    .clk(clk), .reset(reset), .vclk(vclk),
    .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr), .io_din(io_din), .io_dout(io_dout),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .cpu_wait(cpu_wait),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rsel(vram_rsel), .vram_rdata(vram_rdata),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6),
    .cmask(cmask), .bgc(bgc), .mask(mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Six-plane VRAM model: writes on we, read data one cycle after address
  always @(posedge clk) begin
    for (int n = 0; n < 6; n++)
      if (vram_we[n]) plane[n+1][vram_addr] <= vram_wdata;
    vram_rdata <= (vram_rsel >= 3'd1 && vram_rsel <= 3'd6) ? plane[vram_rsel][vram_addr] : 8'h00;
  end

  always @(posedge clk) vclk_at_edge <= vclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scores VRAM write pulses and completed CPU reads
  always @(negedge clk) begin
    exp_wr_t e;
    if (reset) begin
      wait_prev <= 1'b0;
    end else begin
      if (vram_we != 6'd0) begin
        check("we_in_video_slot", vclk_at_edge, 1'b0);
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr 0x%0h we 0x%0h, expected none", vram_addr, vram_we);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", vram_addr, e.addr);
          check("wr_data", vram_wdata, e.data);
          check("wr_we", vram_we, e.we);
        end
      end
      if (wait_prev && !cpu_wait && rd_q.size() > 0)
        check("rd_data", mem_dout, rd_q.pop_front());
      wait_prev <= cpu_wait;
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    io_addr = a; io_din = d; io_wr = 1'b1;
    @(posedge clk); #1;
    io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a);
    io_addr = a; io_rd = 1'b1;
    @(posedge clk); #1;
    io_rd = 1'b0;
  endtask

  task automatic mem_write(input logic [12:0] a, input logic [7:0] d,
                           input logic [5:0] exp_we, input bit expect_issue);
    exp_wr_t e;
    mem_cs = 1'b1; mem_wr = 1'b1; mem_addr = a; mem_din = d;
    if (expect_issue) begin
      e.addr = a; e.data = d; e.we = exp_we;
      exp_wr_q.push_back(e);
    end
    @(posedge clk); #1;
    mem_wr = 1'b0; mem_cs = 1'b0;
  endtask

  task automatic mem_read(input logic [12:0] a, input logic [7:0] exp);
    mem_cs = 1'b1; mem_rd = 1'b1; mem_addr = a;
    rd_q.push_back(exp);
    @(negedge clk);
    check("rd_wait_comb", cpu_wait, 1'b1);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int i = 0;
    while ((exp_wr_q.size() != 0 || rd_q.size() != 0) && i < max_cycles) begin
      @(negedge clk); #1;
      i++;
    end
    check(name, exp_wr_q.size() + rd_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic burst_write(input logic [12:0] a, input logic [7:0] d, input logic [5:0] we);
    exp_wr_t e;
    mem_addr = a; mem_din = d;
    e.addr = a; e.data = d; e.we = we;
    exp_wr_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb_exp;
    int k;
    reset = 1'b1; vclk = 1'b0;
    io_wr = 1'b0; io_rd = 1'b0; io_addr = '0; io_din = '0;
    mem_cs = 1'b0; mem_wr = 1'b0; mem_rd = 1'b0; mem_addr = '0; mem_din = '0;
    idle(2);

    // Reset state
    check("rst_vram_we", vram_we, 6'd0);
    check("rst_cpu_wait", cpu_wait, 1'b0);
    check("rst_io_dout", io_dout, 8'hFF);
    check("rst_mem_dout", mem_dout, 8'h00);
    check("rst_vram_addr", vram_addr, 13'd0);
    check("rst_p1", p1, 8'h00);
    check("rst_mask", mask, 8'h00);
    reset = 1'b0;
    idle(1);

    // Register decode
    io_write(8'hF5, 8'h11);
    check("p1_next_cycle", p1, 8'h11);
    check("mask_before", mask, 8'h00);
    io_write(8'hFE, 8'h3F);
    check("mask_next_cycle", mask, 8'h3F);
    check("p2_untouched", p2, 8'h00);
    check("cmask_untouched", cmask, 8'h00);
    check("bgc_untouched", bgc, 8'h00);
    io_write(8'hF6, 8'h22); io_write(8'hF7, 8'h33); io_write(8'hF8, 8'h44);
    io_write(8'hF9, 8'h55); io_write(8'hFA, 8'h66);
    io_write(8'hFB, 8'hC3); io_write(8'hFC, 8'h81);
    io_write(8'hF4, 8'h77);
    io_write(8'hFD, 8'h99);
    check("p2", p2, 8'h22); check("p3", p3, 8'h33); check("p4", p4, 8'h44);
    check("p5", p5, 8'h55); check("p6", p6, 8'h66);
    check("cmask", cmask, 8'hC3); check("bgc", bgc, 8'h81);
    check("p1_after_ignored", p1, 8'h11);
    check("mask_after_ignored", mask, 8'h3F);

    // Readback (or constant 0xFF without the option)
    io_read(8'hF5);
`ifdef VDP_READBACK_EN
    rb_exp = 8'h11;
`else
    rb_exp = 8'hFF;
`endif
    check("io_readback_p1", io_dout, rb_exp);

    // Single buffered write
    io_write(8'hF2, 8'h05);
    mem_write(13'h0100, 8'hA5, 6'b000101, 1'b1);
    wait_drain(2, "write_latency");

    // Write held off by video slot; mask sampled at push time
    vclk = 1'b1;
    mem_write(13'h0123, 8'h3C, 6'b000101, 1'b1);
    io_write(8'hF2, 8'h3F);
    idle(2);
    check("held_during_vclk", exp_wr_q.size(), 1);
    vclk = 1'b0;
    wait_drain(2, "vclk_release_latency");

    // Three back-to-back writes into a depth-2 buffer
    io_write(8'hF2, 8'h30);
    vclk = 1'b1;
    mem_cs = 1'b1; mem_wr = 1'b1;
    burst_write(13'h0010, 8'h01, 6'h30);
    @(negedge clk); check("wait_wr1", cpu_wait, 1'b0);
    @(posedge clk); #1;
    burst_write(13'h0011, 8'h02, 6'h30);
    @(negedge clk); check("wait_wr2", cpu_wait, 1'b0);
    @(posedge clk); #1;
    burst_write(13'h0012, 8'h03, 6'h30);
    @(negedge clk); check("wait_wr3_full", cpu_wait, 1'b1);
    @(posedge clk); #1;
    mem_wr = 1'b0; mem_cs = 1'b0;
    @(negedge clk); check("wait_write_held", cpu_wait, 1'b1);
    @(posedge clk); #1;
    idle(2);
    check("burst_held_during_vclk", exp_wr_q.size(), 3);
    vclk = 1'b0;
    wait_drain(12, "burst_drain");
    check("wait_released", cpu_wait, 1'b0);

    // Read after write through plane 2
    io_write(8'hF2, 8'h02);
    io_write(8'hF1, 8'h02);
    mem_write(13'h0200, 8'h5A, 6'b000010, 1'b1);
    mem_read(13'h0200, 8'h5A);
    wait_drain(10, "read_after_write");

    // Invalid banks answer 0xFF one cycle later without touching VRAM
    io_write(8'hF1, 8'h07);
    mem_read(13'h0333, 8'hFF);
    wait_drain(2, "bank7_latency");
    check("bank7_no_vram_access", vram_addr, 13'h0200);
    io_write(8'hF1, 8'h02);
    mem_read(13'h0200, 8'h5A);
    wait_drain(10, "reread");
    io_write(8'hF1, 8'h00);
    mem_read(13'h0333, 8'hFF);
    wait_drain(2, "bank0_latency");
    check("bank0_no_vram_access", vram_addr, 13'h0200);

    // Reset in the middle of a WRITE, with a second entry still buffered
    io_write(8'hF2, 8'h0F);
    vclk = 1'b1;
    mem_write(13'h0400, 8'hAA, 6'h0F, 1'b1);
    mem_write(13'h0401, 8'hBB, 6'h0F, 1'b0);
    vclk = 1'b0;
    k = 0;
    while (vram_we == 6'd0 && k < 4) begin
      @(negedge clk); #1;
      k++;
    end
    check("write_before_reset", vram_we, 6'h0F);
    #1 reset = 1'b1;
    #1;
    check("reset_we_async", vram_we, 6'd0);
    check("reset_cpu_wait", cpu_wait, 1'b0);
    check("reset_io_dout", io_dout, 8'hFF);
    check("reset_p1", p1, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(6);
    check("fifo_flushed", exp_wr_q.size(), 0);
    check("cpu_wait_after_reset", cpu_wait, 1'b0);
    check("rd_queue_empty", rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
